// File: rtl/player_cmd_sched.sv
// Per-player command scheduler: synchronizes buttons, arbitrates actions and issues one
// frame-locked command set per frame_tick. Define PLAYER_SCHED_JUMP_BUFFER_EN to buffer blocked jumps.
module player_cmd_sched #(
  parameter int unsigned DEFEND_HOLD = 30,
  parameter int unsigned DEFEND_COOL = 60
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_tick,
  input  logic freeze,
  input  logic btn_right,
  input  logic btn_left,
  input  logic btn_jump,
  input  logic btn_squat,
  input  logic btn_defend,
  output logic step,
  output logic right,
  output logic left,
  output logic jump,
  output logic squat,
  output logic defend,
  output logic cool_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    COOL  = 2'd2
  } dstate_t;

  localparam logic [7:0] HOLD_INIT = 8'(DEFEND_HOLD - 1);
  localparam logic [7:0] COOL_INIT = 8'(DEFEND_COOL - 1);

  // Bit order {right, left, jump, squat, defend}
  logic [4:0] raw;
  logic [4:0] sync1;
  logic [4:0] sync2;
  logic       jump_d3;

  logic       lvl_right;
  logic       lvl_left;
  logic       lvl_jump;
  logic       lvl_squat;
  logic       lvl_defend;
  logic       jump_rise;
  logic       jump_req;

  dstate_t    state;
  dstate_t    state_next;
  logic [7:0] dcnt;
  logic [7:0] dcnt_next;
  logic       rearm;
  logic       rearm_next;
  logic       jump_pend;
  logic       jump_pend_next;

  logic       guard_enter;
  logic       guard_hold;
  logic       defend_now;

  logic       cmd_right;
  logic       cmd_left;
  logic       cmd_jump;
  logic       cmd_squat;
  logic       cmd_defend;

  assign raw        = {btn_right, btn_left, btn_jump, btn_squat, btn_defend};
  assign lvl_right  = sync2[4];
  assign lvl_left   = sync2[3];
  assign lvl_jump   = sync2[2];
  assign lvl_squat  = sync2[1];
  assign lvl_defend = sync2[0];
  assign jump_rise  = lvl_jump & ~jump_d3;
  // An edge seen in the tick cycle itself still counts for that tick
  assign jump_req   = jump_pend | jump_rise;

  assign guard_enter = (state == IDLE)  & lvl_defend & rearm & ~freeze;
  assign guard_hold  = (state == GUARD) & lvl_defend & ~freeze & (dcnt != 8'd0);
  assign defend_now  = guard_enter | guard_hold;

  // Button synchronizers plus the jump edge-detect flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 5'b00000;
      sync2   <= 5'b00000;
      jump_d3 <= 1'b0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      jump_d3 <= sync2[2];
    end
  end

  // Defend FSM state, frame counter, rearm and jump capture registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dcnt      <= 8'd0;
      rearm     <= 1'b1;
      jump_pend <= 1'b0;
    end else begin
      state     <= state_next;
      dcnt      <= dcnt_next;
      rearm     <= rearm_next;
      jump_pend <= jump_pend_next;
    end
  end

  // Defend FSM next state; the counter only moves on frame ticks
  always_comb begin
    state_next = state;
    dcnt_next  = dcnt;
    rearm_next = rearm | ~lvl_defend;
    if (frame_tick) begin
      case (state)
        IDLE: begin
          if (guard_enter) begin
            state_next = GUARD;
            dcnt_next  = HOLD_INIT;
            rearm_next = 1'b0;
          end else begin
            state_next = IDLE;
          end
        end
        GUARD: begin
          if (guard_hold) begin
            dcnt_next = dcnt - 8'd1;
          end else begin
            state_next = COOL;
            dcnt_next  = COOL_INIT;
          end
        end
        COOL: begin
          if (dcnt == 8'd0) begin
            state_next = IDLE;
          end else begin
            dcnt_next = dcnt - 8'd1;
          end
        end
        default: begin
          state_next = IDLE;
          dcnt_next  = 8'd0;
        end
      endcase
    end else begin
      state_next = state;
    end
  end

`ifdef PLAYER_SCHED_JUMP_BUFFER_EN
  logic [1:0] jump_age;
  logic [1:0] jump_age_next;
  logic       jump_blocked;

  assign jump_blocked = freeze | defend_now;

  // Age of a buffered jump, counted in blocked ticks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      jump_age <= 2'd0;
    end else begin
      jump_age <= jump_age_next;
    end
  end

  // Blocked jumps stay pending and expire on the fourth blocked tick
  always_comb begin
    jump_pend_next = jump_pend;
    jump_age_next  = jump_age;
    if (frame_tick) begin
      if (jump_req && jump_blocked) begin
        if (jump_rise) begin
          jump_pend_next = 1'b1;
          jump_age_next  = 2'd0;
        end else if (jump_age == 2'd3) begin
          jump_pend_next = 1'b0;
          jump_age_next  = 2'd0;
        end else begin
          jump_age_next  = jump_age + 2'd1;
        end
      end else begin
        jump_pend_next = 1'b0;
        jump_age_next  = 2'd0;
      end
    end else if (jump_rise) begin
      jump_pend_next = 1'b1;
      jump_age_next  = 2'd0;
    end else begin
      jump_pend_next = jump_pend;
    end
  end
`else
  // Every tick consumes the pending jump, whether or not it was issued
  always_comb begin
    jump_pend_next = jump_pend;
    if (frame_tick) begin
      jump_pend_next = 1'b0;
    end else if (jump_rise) begin
      jump_pend_next = 1'b1;
    end else begin
      jump_pend_next = jump_pend;
    end
  end
`endif

  // Command arbitration; squat only yields to a jump that is actually issued
  always_comb begin
    cmd_right  = 1'b0;
    cmd_left   = 1'b0;
    cmd_jump   = 1'b0;
    cmd_squat  = 1'b0;
    cmd_defend = 1'b0;
    if (freeze) begin
      cmd_defend = 1'b0;
    end else begin
      cmd_defend = defend_now;
      cmd_right  = lvl_right & ~lvl_left & ~defend_now;
      cmd_left   = lvl_left & ~lvl_right & ~defend_now;
      cmd_jump   = jump_req & ~defend_now;
      cmd_squat  = lvl_squat & ~cmd_jump;
    end
  end

  // Registered outputs: commands appear only in the cycle after a tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step      <= 1'b0;
      right     <= 1'b0;
      left      <= 1'b0;
      jump      <= 1'b0;
      squat     <= 1'b0;
      defend    <= 1'b0;
      cool_busy <= 1'b0;
    end else begin
      step      <= frame_tick;
      right     <= frame_tick & cmd_right;
      left      <= frame_tick & cmd_left;
      jump      <= frame_tick & cmd_jump;
      squat     <= frame_tick & cmd_squat;
      defend    <= frame_tick & cmd_defend;
      cool_busy <= (state_next == COOL);
    end
  end

endmodule

// File: tb/tb_player_cmd_sched.sv
// Scoreboard bench for player_cmd_sched: expected command sets are queued at each tick
// and compared when step appears.
module tb_player_cmd_sched;

  localparam int unsigned HOLD = 3;
  localparam int unsigned COOLF = 2;

  logic clk;
  logic rst;
  logic frame_tick;
  logic freeze;
  logic btn_right, btn_left, btn_jump, btn_squat, btn_defend;
  logic step, right, left, jump, squat, defend, cool_busy;
  logic [4:0] cmds;

  int n_cmp;
  int n_bad;
  int n_step;
  logic [4:0] exp_q[$];
  logic [4:0] exp_cur;

  player_cmd_sched #(.DEFEND_HOLD(HOLD), .DEFEND_COOL(COOLF)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .freeze(freeze),
    .btn_right(btn_right), .btn_left(btn_left), .btn_jump(btn_jump),
    .btn_squat(btn_squat), .btn_defend(btn_defend),
    .step(step), .right(right), .left(left), .jump(jump), .squat(squat),
    .defend(defend), .cool_busy(cool_busy)
  );

  assign cmds = {right, left, jump, squat, defend};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop one expected command set per observed step
  always @(negedge clk) begin
    if (!rst) begin
      if (step) begin
        n_step++;
        if (exp_q.size() == 0) begin
          check_val($sformatf("unexpected_step_%0d", n_step), 1, 0);
        end else begin
          exp_cur = exp_q.pop_front();
          check_val($sformatf("cmd_step_%0d", n_step), int'(cmds), int'(exp_cur));
        end
      end else begin
        check_val("cmds_outside_step", int'(cmds), 0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick(input logic [4:0] e);
    exp_q.push_back(e);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic tick2(input logic [4:0] e);
    exp_q.push_back(e);
    exp_q.push_back(e);
    frame_tick = 1'b1;
    @(negedge clk);
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; n_step = 0;
    rst = 1'b1; frame_tick = 1'b0; freeze = 1'b0;
    btn_right = 1'b0; btn_left = 1'b0; btn_jump = 1'b0; btn_squat = 1'b0; btn_defend = 1'b0;
    @(negedge clk);
    idle(2);
    check_val("reset_outputs", int'({step, cmds}), 0);
    check_val("reset_cool_busy", int'(cool_busy), 0);
    rst = 1'b0;
    idle(2);

    // Idle frames
    repeat (3) begin
      tick(5'b00000);
      check_val("idle_cool_busy", int'(cool_busy), 0);
      idle(3);
    end

    // Right and left cancel
    btn_right = 1'b1; btn_left = 1'b1;
    idle(4);
    tick(5'b00000);
    idle(3);
    tick(5'b00000);
    btn_left = 1'b0;
    idle(4);
    tick(5'b10000);
    btn_right = 1'b0;
    idle(4);

    // Jump pulse long before the tick wins over held squat
    btn_squat = 1'b1;
    idle(2);
    btn_jump = 1'b1;
    idle(1);
    btn_jump = 1'b0;
    idle(50);
    tick(5'b00100);
    idle(3);
    tick(5'b00010);
    btn_squat = 1'b0;
    idle(4);

    // Back-to-back ticks
    btn_right = 1'b1;
    idle(4);
    tick2(5'b10000);
    btn_right = 1'b0;
    idle(4);

    // Defend held 10 ticks: guard 3, cool 2, no retrigger
    btn_defend = 1'b1;
    idle(4);
    for (int k = 1; k <= 10; k++) begin
      tick((k <= 3) ? 5'b00001 : 5'b00000);
      check_val($sformatf("cool_busy_tick_%0d", k), int'(cool_busy), (k == 4 || k == 5) ? 1 : 0);
      idle(3);
    end
    btn_defend = 1'b0;
    idle(4);
    btn_defend = 1'b1;
    idle(4);
    tick(5'b00001);

    // Reset mid-guard, defend kept held
    idle(5);
    rst = 1'b1;
    idle(1);
    check_val("midrst_outputs", int'({step, cmds}), 0);
    check_val("midrst_cool_busy", int'(cool_busy), 0);
    idle(2);
    rst = 1'b0;
    idle(4);
    tick(5'b00001);

    // Release into cooldown, then reset clears cool_busy
    btn_defend = 1'b0;
    idle(4);
    tick(5'b00000);
    check_val("cool_after_release", int'(cool_busy), 1);
    idle(3);
    rst = 1'b1;
    idle(1);
    check_val("rst_clears_cool", int'(cool_busy), 0);
    rst = 1'b0;
    idle(3);

    // Freeze across a tick with a jump edge and right held
    freeze = 1'b1;
    btn_right = 1'b1;
    idle(2);
    btn_jump = 1'b1;
    idle(1);
    btn_jump = 1'b0;
    idle(4);
    tick(5'b00000);
    idle(3);
    freeze = 1'b0;
    idle(1);
`ifdef PLAYER_SCHED_JUMP_BUFFER_EN
    tick(5'b10100);
`else
    tick(5'b10000);
`endif
    btn_right = 1'b0;
    idle(5);

    check_val("scoreboard_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
